// File: rtl/sync_fifo_param.sv
// Single-clock circular-buffer FIFO with an explicit occupancy counter, optional
// first-word-fall-through read, threshold flags and sticky overflow/underflow errors.
module sync_fifo_param #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned FWFT       = 0,
    parameter int unsigned AF_THRESH  = (1 << ADDR_WIDTH) - 2,
    parameter int unsigned AE_THRESH  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clr
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LvlFull = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] LvlAf   = (ADDR_WIDTH + 1)'(AF_THRESH);
    localparam logic [ADDR_WIDTH:0] LvlAe   = (ADDR_WIDTH + 1)'(AE_THRESH);
    localparam logic [ADDR_WIDTH:0] LvlOne  = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PtrOne = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;

    // Flags come from the registered level only.
    always_comb begin
        full         = (level_q == LvlFull);
        empty        = (level_q == '0);
        almost_full  = (level_q >= LvlAf);
        almost_empty = (level_q <= LvlAe);
        level        = level_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

    always_comb begin
        wr_acc   = wr_en && !full;
        rd_acc   = rd_en && !empty;
        wr_ptr_d = wr_acc ? wr_ptr_q + PtrOne : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + PtrOne : rd_ptr_q;
        level_d  = level_q;
        if (wr_acc && !rd_acc) begin
            level_d = level_q + LvlOne;
        end else if (!wr_acc && rd_acc) begin
            level_d = level_q - LvlOne;
        end
        // A new error in the same cycle as err_clr keeps the flag set.
        overflow_d  = (wr_en && full) ? 1'b1 : (err_clr ? 1'b0 : overflow_q);
        underflow_d = (rd_en && empty) ? 1'b1 : (err_clr ? 1'b0 : underflow_q);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    if (FWFT != 0) begin : g_fwft
        assign rd_data = mem[rd_ptr_q];
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_data_q;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                rd_data_q <= '0;
            end else if (rd_acc) begin
                rd_data_q <= mem[rd_ptr_q];
            end
        end

        assign rd_data = rd_data_q;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, parametrised FIFO. It is the synchronous-domain successor to the team's dual-clock FIFO, for intra-domain buffering in the sequencer/RX data paths.
Adds features the dual-clock version lacks: selectable first-word-fall-through (FWFT) read mode, a fill-level output, programmable almost-full/almost-empty flags, and sticky overflow/underflow error flags with clear.
Pointer-based circular buffer of 2^ADDR_WIDTH entries, with an explicit occupancy counter.

Parameters:
DATA_WIDTH, 16, word width in bits (>=1)
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2^ADDR_WIDTH (>=1)
FWFT, 0, 0 = standard registered read (1-cycle latency); 1 = first-word-fall-through
AF_THRESH, 2^ADDR_WIDTH-2, almost_full asserted when level >= AF_THRESH
AE_THRESH, 2, almost_empty asserted when level <= AE_THRESH

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
wr_data  in  DATA_WIDTH  write data
wr_en  in  1  write request
full  out  1  level == DEPTH
almost_full  out  1  level >= AF_THRESH
rd_en  in  1  read request (FWFT: pop/acknowledge)
rd_data  out  DATA_WIDTH  read data
empty  out  1  level == 0
almost_empty  out  1  level <= AE_THRESH
level  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: write attempted while full
underflow  out  1  sticky: read attempted while empty
err_clr  in  1  clears overflow/underflow

Behaviour:
- Reset (rst_n=0 sampled at edge): wr_ptr=0, rd_ptr=0, level=0, empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0), overflow=0, underflow=0, rd_data=0 (standard mode). Memory contents are not reset. Reset overrides all other inputs in the same cycle, including mid-burst.
- Write accept: wr_acc = wr_en && !full. On accept, mem[wr_ptr] <= wr_data and wr_ptr <= wr_ptr+1. The pointer wraps modulo DEPTH.
- Read accept: rd_acc = rd_en && !empty. On accept, rd_ptr <= rd_ptr+1, wrapping modulo DEPTH.
- Full/empty are evaluated on the registered level before the edge. There is no write-through-when-full and no read-through-when-empty.
- Level update: level <= level + wr_acc - rd_acc. Simultaneous accepted read and write leave level unchanged; both pointers advance.
- Flags empty, full, almost_empty and almost_full are decoded from the level register. They change on the same edge as level, so a write at edge N gives empty=0 after edge N.
- Standard mode (FWFT=0): on rd_acc at edge N, rd_data <= mem[rd_ptr], valid after edge N (1-cycle latency). rd_data holds its value when there is no accept.
- FWFT mode (FWFT=1): rd_data = mem[rd_ptr] continuously. It is valid whenever empty=0, and rd_en consumes the word. rd_data is don't-care while empty=1.
- Errors: wr_en && full at an edge sets overflow=1 and drops the data, with pointers and level unchanged. rd_en && empty sets underflow=1, with rd_data unchanged in standard mode.
- err_clr=1 clears both error flags. If a new error occurs in the same cycle as err_clr, the set wins and the flag stays 1.
- No state machine beyond the pointer/level registers. Combinational paths: flags from level only. In FWFT, rd_data comes from memory only.

Test Plan:
1. Reset, then FWFT=0. Write 0..15 on 16 consecutive edges. Required: full=1 after the 16th edge, level=16, almost_full=1 from level 14, overflow=0.
2. From full, one extra write of 0xDEAD. Required: overflow=1, level stays 16. Read 16 words: rd_data is 0..15, each one cycle after its rd_en edge, and 0xDEAD never appears. empty=1 after the 16th read.
3. Set wr_en=rd_en=1 continuously for 40 cycles starting from level 8, with incrementing data. Required: level constant at 8, pointers wrap twice, read sequence strictly incrementing with no gap.
4. FWFT=1: write 0x1234 at edge N. Required: empty=0 and rd_data=0x1234 after edge N with no rd_en. One rd_en gives empty=1 and level=0.
5. Read while empty. Required: underflow=1, level 0. Pulse err_clr together with a second empty read: underflow stays 1. err_clr alone: underflow=0.
6. Assert rst_n=0 for one edge at level 5 mid-burst. Required: level=0, empty=1, almost_empty=1, overflow=underflow=0, rd_data=0. The next write/read pair returns the newly written value.
